seq_addsub_n: RTL and testbench

- Parametrised multi-cycle adder/subtractor; the next generation of the team's 4-bit full adder with carryout and overflow.
- Accepts WIDTH-bit two's-complement operands and processes CHUNK bits per clock in a ripple fashion.
- Reports sum, carryout, signed overflow and a zero flag through a start/busy/done handshake.
- Used in the datapath wherever a wide add/sub must fit a short clock period at the cost of latency.

---
 rtl/seq_addsub_n.sv | 128 ++++++++++++
 tb/tb_seq_addsub_n.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub_n.sv
// Multi-cycle WIDTH-bit adder/subtractor: ripples CHUNK bits per clock and
// reports sum, carryout, signed overflow and zero via a start/busy/done handshake.
module seq_addsub_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    // Select the operand slices addressed by the chunk counter
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (cnt == CW'(i)) begin
                chunk_a = op_a[i*CHUNK +: CHUNK];
                chunk_b = op_b[i*CHUNK +: CHUNK];
            end
        end
    end

    // One ripple step: chunk add with incoming carry
    always_comb begin
        chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
    end

    // Result register with the current chunk merged in, plus overflow of that result
    always_comb begin
        res_next = res;
        for (int i = 0; i < int'(N); i++) begin
            if (cnt == CW'(i)) begin
                res_next[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end
        end
        ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                   (res_next[WIDTH-1] != op_a[WIDTH-1]);
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b, seed carry with 1
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= chunk_sum[CHUNK];
                    if (cnt == LAST) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= res_next;
                        carryout <= chunk_sum[CHUNK];
                        overflow <= ovf_next;
                        zero     <= (res_next == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub_n.sv
// Scoreboard bench for seq_addsub_n: an 8-bit/4-bit instance and a default 32-bit instance.
module tb_seq_addsub_n;

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ov;
        logic        z;
        int          edge_exp;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ndone8 = 0;
    int   ndone32 = 0;

    exp_t q8[$];
    exp_t q32[$];

    // 8-bit instance signals
    logic        reset8, start8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, co8, ov8, z8;
    logic [7:0]  sum8;

    // 32-bit instance signals
    logic        reset32, start32, sub32;
    logic [31:0] a32, b32;
    logic        busy32, done32, co32, ov32, z32;
    logic [31:0] sum32;

    seq_addsub_n #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .sub(sub8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .carryout(co8), .overflow(ov8), .zero(z8)
    );

    seq_addsub_n dut32 (
        .clk(clk), .reset(reset32), .start(start32), .sub(sub32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .sum(sum32),
        .carryout(co32), .overflow(ov32), .zero(z32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called right after a negedge; start is seen by the next posedge (E0)
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] es, input logic eco, input logic eov,
                       input logic ez, input bit push);
        exp_t e;
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        if (push) begin
            e.sum = {24'h0, es}; e.co = eco; e.ov = eov; e.z = ez;
            e.edge_exp = cyc + 1 + 2;
            q8.push_back(e);
        end
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] es, input logic eco, input logic eov,
                        input logic ez);
        exp_t e;
        a32 = a; b32 = b; sub32 = s; start32 = 1'b1;
        e.sum = es; e.co = eco; e.ov = eov; e.z = ez;
        e.edge_exp = cyc + 1 + 8;
        q32.push_back(e);
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic wait8();
        int n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done8_seen", 32'(done8), 32'd1);
    endtask

    task automatic wait32();
        int n = 0;
        while (done32 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done32_seen", 32'(done32), 32'd1);
    endtask

    // Monitor for the 8-bit instance
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                ndone8++;
                chk("d8_done_single", 32'(prev), 32'd0);
                chk("d8_busy_at_done", 32'(busy8), 32'd0);
                if (q8.size() == 0) begin
                    chk("d8_unexpected_done", 32'(q8.size()), 32'd1);
                end else begin
                    e = q8.pop_front();
                    chk("d8_sum", {24'h0, sum8}, e.sum);
                    chk("d8_carryout", 32'(co8), 32'(e.co));
                    chk("d8_overflow", 32'(ov8), 32'(e.ov));
                    chk("d8_zero", 32'(z8), 32'(e.z));
                    chk("d8_latency", 32'(cyc), 32'(e.edge_exp));
                end
            end
            prev = (done8 === 1'b1);
        end
    end

    // Monitor for the 32-bit instance
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done32 === 1'b1) begin
                ndone32++;
                chk("d32_done_single", 32'(prev), 32'd0);
                if (q32.size() == 0) begin
                    chk("d32_unexpected_done", 32'(q32.size()), 32'd1);
                end else begin
                    e = q32.pop_front();
                    chk("d32_sum", sum32, e.sum);
                    chk("d32_carryout", 32'(co32), 32'(e.co));
                    chk("d32_overflow", 32'(ov32), 32'(e.ov));
                    chk("d32_zero", 32'(z32), 32'(e.z));
                    chk("d32_latency", 32'(cyc), 32'(e.edge_exp));
                end
            end
            prev = (done32 === 1'b1);
        end
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        reset8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        reset32 = 1'b1; start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;
        repeat (2) @(negedge clk);
        reset8 = 1'b0; reset32 = 1'b0;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8", {24'h0, sum8}, 32'h0);
        chk("rst_flags8", {29'h0, co8, ov8, z8}, 32'h0);
        chk("rst_busy32", 32'(busy32), 32'd0);
        chk("rst_sum32", sum32, 32'h0);
        @(negedge clk);

        // Basic add, latency and busy
        go8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("busy8_run1", 32'(busy8), 32'd1);
        @(negedge clk);
        chk("busy8_run2", 32'(busy8), 32'd1);
        wait8();

        // Back-to-back adds, each start issued during DONE
        go8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("b2b_busy_after_done", 32'(busy8), 32'd1);
        wait8();
        go8(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
        wait8();
        go8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        wait8();

        // Subtraction
        go8(8'h05, 8'h0C, 1'b1, 8'hF9, 1'b0, 1'b0, 1'b0, 1'b1);
        wait8();
        go8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
        wait8();
        go8(8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        wait8();
        @(negedge clk);
        chk("idle_after_done8", 32'(done8), 32'd0);

        // Start during RUN is ignored
        go8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; sub8 = 1'b0;
        wait8();
        @(negedge clk);

        // Reset mid-operation discards it
        go8(8'h7F, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset8 = 1'b1;
        @(negedge clk);
        reset8 = 1'b0;
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_done", 32'(done8), 32'd0);
        chk("midrst_sum", {24'h0, sum8}, 32'h0);
        chk("midrst_flags", {29'h0, co8, ov8, z8}, 32'h0);
        @(negedge clk);
        chk("midrst_no_done", 32'(done8), 32'd0);
        go8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
        wait8();

        // 32-bit: full carry ripple and wide cases
        go32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        wait32();
        go32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        wait32();
        go32(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        wait32();

        repeat (4) @(negedge clk);
        chk("q8_empty", 32'(q8.size()), 32'd0);
        chk("q32_empty", 32'(q32.size()), 32'd0);
        chk("ndone8", 32'(ndone8), 32'd9);
        chk("ndone32", 32'(ndone32), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
